// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: grants one requester per frame and
// holds off further grants until the frame plus guard time has elapsed.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TicksPerBit = 434,
  parameter int FrameWidth  = 10,
  parameter int GuardTicks  = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [8*NUM_REQ-1:0]       i_data,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic                       o_send,
  output logic [7:0]                 o_frame,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int PW         = $clog2(NUM_REQ);
  localparam int HoldCycles = FrameWidth * TicksPerBit + GuardTicks;
  localparam int CW         = $clog2(HoldCycles + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [7:0]    byte_arr [NUM_REQ];
  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      byte_arr[k] = i_data[8*k +: 8];
    end
  end

  // Winner search starts at ptr and wraps, so the last granted requester is tried last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      o_ack      <= '0;
      o_send     <= 1'b0;
      o_frame    <= 8'h00;
      o_busy     <= 1'b0;
      o_grant_id <= '0;
    end else begin
      o_ack  <= '0;
      o_send <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          o_ack      <= NUM_REQ'(1) << win;
          o_send     <= 1'b1;
          o_frame    <= byte_arr[win];
          o_grant_id <= win;
          o_busy     <= 1'b1;
          cnt        <= CW'(HoldCycles - 1);
          state      <= WAIT;
        end
      end else begin
        // Requests are ignored here; they stay pending on i_req until the next IDLE cycle.
        if (cnt == '0) begin
          o_busy <= 1'b0;
          state  <= IDLE;
          ptr    <= (o_grant_id == PW'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short bit time (HoldCycles = 41) and a
// behavioural transmitter that records accepted bytes and flags sends arriving while busy.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TPB  = 4;
  localparam int FW   = 10;
  localparam int GT   = 1;
  localparam int HOLD = FW * TPB + GT;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  i_req = '0;
  logic [31:0] i_data = '0;
  logic [3:0]  o_ack;
  logic        o_send;
  logic [7:0]  o_frame;
  logic        o_busy;
  logic [1:0]  o_grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ), .TicksPerBit(TPB), .FrameWidth(FW), .GuardTicks(GT)
  ) dut (
    .CLK(CLK), .RST(RST), .i_req(i_req), .i_data(i_data), .o_ack(o_ack),
    .o_send(o_send), .o_frame(o_frame), .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference transmitter: takes i_send on the clock edge, busy for one full frame.
  logic       tx_en = 1'b0;
  int         tx_cnt = 0;
  int         tx_drops = 0;
  logic [7:0] tx_bytes [$];
  always @(posedge CLK) begin
    if (!tx_en) begin
      tx_cnt   <= 0;
      tx_drops <= 0;
      tx_bytes.delete();
    end else if (o_send) begin
      if (tx_cnt != 0) tx_drops <= tx_drops + 1;
      else begin
        tx_bytes.push_back(o_frame);
        tx_cnt <= FW * TPB;
      end
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    i_req = '0;
    step(2);
    RST = 1'b0;
  endtask

  task automatic wait_send(output int at, output bit ok);
    int n;
    n = 0;
    while (o_send !== 1'b1 && n < 3 * HOLD) begin
      step();
      n++;
    end
    ok = (o_send === 1'b1);
    at = cyc;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    i_req = 4'hF;
    i_data = 32'hDEADBEEF;
    step(2);
    checks++; if (o_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", o_ack); end
    checks++; if (o_send !== 1'b0) begin errors++; $display("FAIL reset_send got %b want 0", o_send); end
    checks++; if (o_frame !== 8'h00) begin errors++; $display("FAIL reset_frame got %h want 00", o_frame); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", o_grant_id); end
    RST = 1'b0;
    i_req = '0;
    step(2);
    checks++; if (o_send !== 1'b0 || o_busy !== 1'b0 || o_ack !== 4'b0) begin
      errors++; $display("FAIL idle_noreq got send=%b busy=%b ack=%b want 0 0 0000", o_send, o_busy, o_ack);
    end
  endtask

  task automatic test_single();
    int bad;
    do_reset();
    i_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    i_req = 4'b0100;
    step();
    i_req = '0;
    checks++; if (o_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", o_ack); end
    checks++; if (o_send !== 1'b1) begin errors++; $display("FAIL single_send got %b want 1", o_send); end
    checks++; if (o_frame !== 8'hA5) begin errors++; $display("FAIL single_frame got %h want a5", o_frame); end
    checks++; if (o_grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got %0d want 2", o_grant_id); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", o_busy); end
    bad = 0;
    for (int k = 2; k <= HOLD; k++) begin
      step();
      if (o_busy !== 1'b1 || o_send !== 1'b0 || o_ack !== 4'b0 || o_frame !== 8'hA5) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_hold got %0d bad cycles want 0", bad); end
    step();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", o_busy); end
  endtask

  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int at, last;
    bit ok;
    do_reset();
    i_data = 32'h13121110;
    i_req = 4'hF;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_send(at, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout grant %0d got none want send", g); end
      checks++; if (int'(o_grant_id) != exp_id[g] || o_ack !== (4'b1 << exp_id[g]) || o_frame !== 8'(8'h10 + exp_id[g])) begin
        errors++; $display("FAIL rr_grant %0d got id=%0d ack=%b frame=%h want id=%0d", g, o_grant_id, o_ack, o_frame, exp_id[g]);
      end
      if (g > 0) begin
        checks++; if (at - last != HOLD + 1) begin errors++; $display("FAIL rr_spacing got %0d want %0d", at - last, HOLD + 1); end
      end
      last = at;
      i_req[o_grant_id] = 1'b0;
      step();
      i_req = 4'hF;
    end
    i_req = '0;
  endtask

  task automatic test_wrap();
    int at;
    bit ok;
    do_reset();
    i_data = 32'hD3C2B1A0;
    i_req = 4'b1000;
    wait_send(at, ok);
    checks++; if (!ok || o_grant_id !== 2'd3) begin errors++; $display("FAIL wrap_first got id=%0d want 3", o_grant_id); end
    i_req = 4'b1001;
    step();
    wait_send(at, ok);
    checks++; if (!ok || o_grant_id !== 2'd0 || o_frame !== 8'hA0) begin
      errors++; $display("FAIL wrap_second got id=%0d frame=%h want 0 a0", o_grant_id, o_frame);
    end
    i_req = 4'b1000;
    step();
    wait_send(at, ok);
    checks++; if (!ok || o_grant_id !== 2'd3 || o_frame !== 8'hD3) begin
      errors++; $display("FAIL wrap_third got id=%0d frame=%h want 3 d3", o_grant_id, o_frame);
    end
    i_req = '0;
  endtask

  task automatic test_wait_req();
    int bad;
    do_reset();
    i_data = 32'h000000AA;
    i_req = 4'b0001;
    step();
    i_req = '0;
    checks++; if (o_ack !== 4'b0001) begin errors++; $display("FAIL waitreq_first got %b want 0001", o_ack); end
    step(4);
    i_req = 4'b0010;
    bad = 0;
    for (int k = 6; k <= HOLD + 1; k++) begin
      step();
      if (o_ack !== 4'b0 || o_send !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL waitreq_ignored got %0d early acks want 0", bad); end
    step();
    checks++; if (o_ack !== 4'b0010 || o_send !== 1'b1) begin
      errors++; $display("FAIL waitreq_grant got ack=%b send=%b want 0010 1", o_ack, o_send);
    end
    i_req = '0;
  endtask

  task automatic test_reset_mid();
    int at;
    bit ok;
    do_reset();
    i_data = 32'h775A6644;
    i_req = 4'b0100;
    wait_send(at, ok);
    i_req = '0;
    checks++; if (!ok || o_grant_id !== 2'd2) begin errors++; $display("FAIL rstmid_pre got id=%0d want 2", o_grant_id); end
    step(HOLD);
    i_req = 4'b1010;
    step();
    checks++; if (o_send !== 1'b1 || o_grant_id !== 2'd3) begin
      errors++; $display("FAIL rstmid_grant3 got send=%b id=%0d want 1 3", o_send, o_grant_id);
    end
    i_req = 4'b0010;
    step(9);
    RST = 1'b1;
    i_req = 4'b1010;
    step();
    checks++; if (o_busy !== 1'b0 || o_send !== 1'b0 || o_ack !== 4'b0) begin
      errors++; $display("FAIL rstmid_ctrl got busy=%b send=%b ack=%b want 0 0 0000", o_busy, o_send, o_ack);
    end
    checks++; if (o_frame !== 8'h00 || o_grant_id !== 2'd0) begin
      errors++; $display("FAIL rstmid_data got frame=%h id=%0d want 00 0", o_frame, o_grant_id);
    end
    RST = 1'b0;
    step();
    checks++; if (o_send !== 1'b1 || o_grant_id !== 2'd1 || o_ack !== 4'b0010 || o_frame !== 8'h66) begin
      errors++; $display("FAIL rstmid_after got send=%b id=%0d ack=%b frame=%h want 1 1 0010 66", o_send, o_grant_id, o_ack, o_frame);
    end
    i_req = '0;
  endtask

  task automatic test_back_to_back();
    int at, first, n, bad;
    bit ok;
    do_reset();
    tx_en = 1'b1;
    i_data = {16'h0000, 8'hC3, 8'h55};
    i_req = 4'b0011;
    wait_send(first, ok);
    checks++; if (!ok || o_frame !== 8'h55) begin errors++; $display("FAIL b2b_first got frame=%h want 55", o_frame); end
    i_req = 4'b0010;
    bad = 0;
    n = 0;
    step();
    while (o_send !== 1'b1 && n < 3 * HOLD) begin
      if (o_frame !== 8'h55) bad++;
      step();
      n++;
    end
    at = cyc;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame_held got %0d changes want 0", bad); end
    checks++; if (o_send !== 1'b1 || o_frame !== 8'hC3 || o_grant_id !== 2'd1) begin
      errors++; $display("FAIL b2b_second got send=%b frame=%h id=%0d want 1 c3 1", o_send, o_frame, o_grant_id);
    end
    checks++; if (at - first != HOLD + 1) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", at - first, HOLD + 1); end
    i_req = '0;
    step(FW * TPB + 4);
    checks++; if (tx_drops != 0) begin errors++; $display("FAIL b2b_drops got %0d want 0", tx_drops); end
    checks++; if (tx_bytes.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", tx_bytes.size());
    end else if (tx_bytes[0] !== 8'h55 || tx_bytes[1] !== 8'hC3) begin
      errors++; $display("FAIL b2b_bytes got %h %h want 55 c3", tx_bytes[0], tx_bytes[1]);
    end
    tx_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_wait_req();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The module SHALL have parameter TicksPerBit, default 434, giving CLK cycles per UART bit (50_000_000 / 115200).
REQ-003 The module SHALL have parameter FrameWidth, default 10, giving the UART bits per frame (start + 8 data + stop).
REQ-004 The module SHALL have parameter GuardTicks, default 1, giving extra idle cycles added after each frame (≥1).
REQ-005 The module SHALL use one clock; reset is synchronous and active-high.
REQ-006 CLK  input  1  system clock; all logic on its rising edge.
REQ-007 RST  input  1  synchronous, active-high reset.
REQ-008 i_req  input  NUM_REQ  per-requester level request; bit k belongs to requester k.
REQ-009 i_data  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-010 o_ack  output  NUM_REQ  one-hot, one-cycle pulse; the byte from that requester has been taken.
REQ-011 o_send  output  1  one-cycle send strobe to the UART transmitter (drives its i_send).
REQ-012 o_frame  output  8  byte to the transmitter (drives its i_frame); valid while o_send=1, held otherwise.
REQ-013 o_busy  output  1  high while a frame is in flight or its guard time is running.
REQ-014 o_grant_id  output  $clog2(NUM_REQ)  index of the most recently granted requester.

Function
REQ-015 The module SHALL define HoldCycles = FrameWidth*TicksPerBit + GuardTicks.
REQ-016 The down-counter SHALL be $clog2(HoldCycles+1) bits wide.
REQ-017 The module SHALL implement two states, IDLE and WAIT, with a round-robin pointer ptr of width $clog2(NUM_REQ).
REQ-018 In IDLE with i_req == 0, the module SHALL stay in IDLE with all strobes low.
REQ-019 In IDLE with i_req != 0 in cycle t, the winner SHALL be the first set bit found searching ptr, ptr+1, … with wrap modulo NUM_REQ.
REQ-020 At the end of cycle t, the module SHALL set the following registers: o_ack = one-hot(winner), o_send = 1, o_frame = i_data slice of the winner, o_grant_id = winner, o_busy = 1, counter = HoldCycles-1, state = WAIT.
REQ-021 o_ack and o_send SHALL be high in cycle t+1 only; the grant latency from request to send is 1 cycle.
REQ-022 In WAIT, the counter SHALL decrement once per cycle, and o_send and o_ack SHALL stay 0.
REQ-023 When the counter is 0 in WAIT, the module SHALL clear o_busy, set state = IDLE and set ptr = (o_grant_id+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
REQ-024 o_busy SHALL be high in cycles t+1 … t+HoldCycles inclusive; the earliest next grant decision is cycle t+HoldCycles+1, and the next o_send is at t+HoldCycles+2.
REQ-025 i_req SHALL be ignored in WAIT; requests are neither lost nor acknowledged while busy.
REQ-026 Requesters SHALL hold i_req and i_data stable until o_ack and drop i_req after it; an i_req still high in IDLE is a new request.
REQ-027 When several requests arrive simultaneously, exactly one SHALL be granted per frame; no requester waits more than NUM_REQ-1 frames while asserting.
REQ-028 o_frame SHALL be unchanged except on a grant.

Reset
REQ-029 When RST=1 at a rising edge, the module SHALL set: state = IDLE, ptr = 0, counter = 0, o_ack = 0, o_send = 0, o_frame = 8'h00, o_busy = 0, o_grant_id = 0.
REQ-030 RST SHALL take priority over all other inputs.
REQ-031 A reset during WAIT SHALL abort the guard time with no o_send and no o_ack in the reset cycle or the following cycle.
REQ-032 The arbiter SHALL clear o_send while RST is high and SHALL NOT reset the transmitter itself.

Verification (TicksPerBit=4, FrameWidth=10, GuardTicks=1 → HoldCycles=41, NUM_REQ=4)
REQ-033 Single request: i_req=4'b0100, byte 2=8'hA5 in cycle t → cycle t+1 shows o_ack=4'b0100, o_send=1, o_frame=8'hA5, o_grant_id=2; o_busy stays high for 41 cycles; o_busy=0 at t+42.
REQ-034 Simultaneous requests, all four held, re-raised after each ack → grant order 0,1,2,3,0; consecutive o_send pulses are exactly 42 cycles apart.
REQ-035 Wrap: after a grant to 3 with ptr=0 … i_req=4'b1001 → requester 0 is granted next, then requester 3.
REQ-036 Request during WAIT: i_req=4'b0010 raised at t+5 and held → no ack until t+42; o_ack=4'b0010 and o_send at t+43.
REQ-037 Reset mid-frame: RST=1 at cycle t+10 → next cycle o_busy=0, o_send=0, o_frame=8'h00, o_grant_id=0; a request held through reset is granted one cycle after RST falls, with ptr=0 priority.
REQ-038 Integration with the UART transmitter (active-low reset held inactive): two back-to-back arbitrated bytes 8'h55 and 8'hC3 → serial line decodes both frames intact and no i_send is dropped.
